uart_rx: RTL and testbench

Asynchronous serial receiver, the downstream counterpart of `uart_tx`. It consumes the `tx_out` line, recovers 8N1 frames (8E1 when parity is compiled in) using 16x oversampling from the system clock, and presents each byte with a one-cycle valid strobe. It contains its own oversample divider and does not use `baud_gen`.

---
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 serial receiver; define UART_RX_PARITY_EN for 8E1 with parity check
module uart_rx #(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 9600,
   parameter int DIV    = CLK_HZ / (BAUD * 16)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       parity_err
);
   localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_IDLE
   } state_t;

   state_t          state, nxt;
   logic            s1, rxs;
   logic [1:0]      fill;
   logic            armed;
   logic [TW-1:0]   tcnt;
   logic [3:0]      scnt;
   logic [2:0]      bcnt;
   logic [7:0]      sh;
   logic            tick, mid, last;
   logic            start_det, start_done, shift_en, good, bad;

   assign tick = (tcnt == TW'(DIV - 1));
   assign mid  = (scnt == 4'd7);
   assign last = (scnt == 4'd15);

   // two-flop synchronizer for the asynchronous line, idling high
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {s1, rxs} <= 2'b11;
      else        {s1, rxs} <= {rx_in, s1};

   // arm only once a real line sample (not the synchronizer reset value) reads high
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fill  <= 2'b00;
         armed <= 1'b0;
      end else begin
         fill  <= {fill[0], 1'b1};
         armed <= armed | (fill[1] & rxs);
      end

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= nxt;

   // next-state logic
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      if (armed && !rxs) nxt = START;
         START:     if (tick && mid) nxt = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA:      if (tick && last && bcnt == 3'd7) nxt = PARITY;
         PARITY:    if (tick && last) nxt = STOP;
`else
         DATA:      if (tick && last && bcnt == 3'd7) nxt = STOP;
`endif
         STOP:      if (tick && last) nxt = rxs ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rxs) nxt = IDLE;
         default:   nxt = IDLE;
      endcase
   end

   // per-state strobes driving the datapath
   always_comb begin
      start_det  = (state == IDLE) && armed && !rxs;
      start_done = (state == START) && tick && mid;
      shift_en   = (state == DATA) && tick && last;
      good       = (state == STOP) && tick && last && rxs;
      bad        = (state == STOP) && tick && last && !rxs;
   end

   // oversample tick, sample and bit counters, restarted on start detection
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tcnt <= '0;
         scnt <= '0;
         bcnt <= '0;
      end else begin
         tcnt <= (start_det || tick) ? '0 : tcnt + 1'b1;
         scnt <= (start_det || start_done) ? 4'd0 : tick ? scnt + 4'd1 : scnt;
         bcnt <= start_det ? 3'd0 : shift_en ? bcnt + 3'd1 : bcnt;
      end

   // shift register, byte output and one-clock status pulses
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sh         <= 8'h00;
         data_out   <= 8'h00;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sh         <= shift_en ? {rxs, sh[7:1]} : sh;
         data_out   <= good ? sh : data_out;
         data_valid <= good;
         frame_err  <= bad;
      end

`ifdef UART_RX_PARITY_EN
   logic par;

   // capture the parity bit and flag an even-parity mismatch alongside data_valid
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         par        <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par        <= (state == PARITY && tick && last) ? rxs : par;
         parity_err <= good && ((^sh) != par);
      end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx driving serial frames at a reduced baud divider
module tb_uart_rx;
   localparam int CLK_HZ = 1_600_000;
   localparam int BAUD   = 10_000;
   localparam int DIV    = CLK_HZ / (BAUD * 16);
   localparam int BP     = 16 * DIV;
`ifdef UART_RX_PARITY_EN
   localparam int LAT    = 3 + 168 * DIV;
`else
   localparam int LAT    = 3 + 152 * DIV;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_in = 1'b1;
   logic [7:0] data_out;
   logic       data_valid, frame_err, parity_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int st_cyc = 0;
   int dv_cyc = 0;
   int dv_cnt = 0;
   int fe_cnt = 0;
   logic dv_prev = 1'b0;
   logic fe_prev = 1'b0;
   logic par_flip = 1'b0;
   logic [8:0] q[$];

   uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in),
      .data_out(data_out), .data_valid(data_valid),
      .frame_err(frame_err), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic line(input logic v, input int n);
      rx_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] d, input logic pe);
      q.push_back({pe, d});
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      st_cyc = cyc;
      line(1'b0, BP);
      for (int i = 0; i < 8; i++) line(d[i], BP);
`ifdef UART_RX_PARITY_EN
      line((^d) ^ par_flip, BP);
`endif
      line(stop, BP);
   endtask

   // scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      logic [8:0] e;
      if (data_valid || frame_err) chk("dv_fe_excl", 32'(data_valid & frame_err), 32'd0);
      if (dv_prev) chk("dv_width", 32'(data_valid), 32'd0);
      if (fe_prev) chk("fe_width", 32'(frame_err), 32'd0);
      if (parity_err) chk("perr_with_dv", 32'(data_valid), 32'd1);
      if (data_valid) begin
         dv_cnt++;
         dv_cyc = cyc;
         chk("dv_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("data", 32'(data_out), 32'(e[7:0]));
            chk("perr", 32'(parity_err), 32'(e[8]));
         end
      end
      if (frame_err) fe_cnt++;
      dv_prev = data_valid;
      fe_prev = frame_err;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc %0d exp finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int dv0, fe0;
      logic [7:0] msg [5];
      msg = '{8'h54, 8'h61, 8'h72, 8'h74, 8'h7A};
      repeat (5) @(negedge clk);
      chk("rst_data", 32'(data_out), 32'h00);
      chk("rst_dv", 32'(data_valid), 32'd0);
      chk("rst_fe", 32'(frame_err), 32'd0);
      chk("rst_pe", 32'(parity_err), 32'd0);
      rst_n = 1'b1;
      line(1'b1, 3 * BP);

      push(8'h54, 1'b0);
      send_frame(8'h54, 1'b1);
      chk("t_q_empty", 32'(q.size()), 32'd0);
      chk("t_latency", 32'(dv_cyc - st_cyc), 32'(LAT));
      line(1'b1, BP);

      for (int i = 0; i < 5; i++) begin
         push(msg[i], 1'b0);
         send_frame(msg[i], 1'b1);
      end
      chk("tartz_q_empty", 32'(q.size()), 32'd0);
      chk("tartz_fe", 32'(fe_cnt), 32'd0);
      line(1'b1, BP);

      line(1'b0, 2 * DIV);
      line(1'b1, BP);
      push(8'h00, 1'b0);
      send_frame(8'h00, 1'b1);
      chk("glitch_q_empty", 32'(q.size()), 32'd0);
      line(1'b1, BP);

      dv0 = dv_cnt;
      send_frame(8'hA5, 1'b0);
      line(1'b0, 2 * BP);
      line(1'b1, BP);
      chk("brk_fe_cnt", 32'(fe_cnt), 32'd1);
      chk("brk_no_dv", 32'(dv_cnt), 32'(dv0));
      chk("brk_data_hold", 32'(data_out), 32'h00);
      push(8'h3C, 1'b0);
      send_frame(8'h3C, 1'b1);
      chk("brk_q_empty", 32'(q.size()), 32'd0);
      line(1'b1, BP);

      dv0 = dv_cnt;
      fe0 = fe_cnt;
      line(1'b0, BP);
      for (int i = 0; i < 4; i++) line(1'b0, BP);
      line(1'b0, BP / 2);
      rst_n = 1'b0;
      line(1'b0, 4);
      chk("midrst_data", 32'(data_out), 32'h00);
      rst_n = 1'b1;
      line(1'b0, BP / 2 - 4);
      for (int i = 0; i < 3; i++) line(1'b1, BP);
      line(1'b1, 3 * BP);
      chk("midrst_no_dv", 32'(dv_cnt), 32'(dv0));
      chk("midrst_no_fe", 32'(fe_cnt), 32'(fe0));
      push(8'h81, 1'b0);
      send_frame(8'h81, 1'b1);
      chk("midrst_q_empty", 32'(q.size()), 32'd0);
      line(1'b1, BP);

`ifdef UART_RX_PARITY_EN
      par_flip = 1'b0;
      push(8'h07, 1'b0);
      send_frame(8'h07, 1'b1);
      line(1'b1, BP);
      par_flip = 1'b1;
      push(8'h07, 1'b1);
      send_frame(8'h07, 1'b1);
      par_flip = 1'b0;
      chk("par_q_empty", 32'(q.size()), 32'd0);
      line(1'b1, BP);
`endif

      chk("final_q_empty", 32'(q.size()), 32'd0);
      chk("final_fe_cnt", 32'(fe_cnt), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
